// File: rtl/hyperbus_udma_tx_prefetch.sv
// Prefetches a programmed number of uDMA beats into a small FIFO ahead of the HyperBus TX datapath.
// Define HYPERBUS_TX_PREFETCH_OUTREG_EN to add a registered output slice behind the FIFO.
module hyperbus_udma_tx_prefetch #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned Depth          = 4,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned CntWidth       = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 clr_i,
    input  logic                 start_i,
    input  logic [CntWidth-1:0]  beats_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 req_o,
    input  logic                 gnt_i,
    input  logic                 valid_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 ready_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned OccW = $clog2(Depth + 1);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
    localparam int unsigned SumW = OccW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t               state, state_n;
    logic [DataWidth-1:0] mem [Depth];
    logic [PtrW-1:0]      wptr, wptr_n, rptr, rptr_n;
    logic [OccW-1:0]      count, count_n, occ_n;
    logic [OutW-1:0]      outstanding, outstanding_n;
    logic [OutW-1:0]      discard, discard_n;
    logic [CntWidth-1:0]  remaining, remaining_n;
    logic [CntWidth-1:0]  popleft, popleft_n;
    logic                 grant, rsp, drop, pop, fifo_rd;
    logic                 done_n, req_n;

`ifdef HYPERBUS_TX_PREFETCH_OUTREG_EN
    logic                 out_valid, out_valid_n;
    logic [DataWidth-1:0] out_data;
`endif

    assign ready_o = 1'b1;

`ifdef HYPERBUS_TX_PREFETCH_OUTREG_EN
    assign valid_o = out_valid;
    assign data_o  = out_data;
`else
    assign valid_o = (count != '0);
    assign data_o  = (count != '0) ? mem[rptr] : '0;
`endif

    always_comb begin
        grant = req_o && gnt_i;
        rsp   = valid_i && (outstanding != '0) && (state != DRAIN);
        drop  = valid_i && (state == DRAIN) && (discard != '0);
`ifdef HYPERBUS_TX_PREFETCH_OUTREG_EN
        pop         = out_valid && ready_i;
        fifo_rd     = (count != '0) && (!out_valid || ready_i);
        out_valid_n = fifo_rd ? 1'b1 : (pop ? 1'b0 : out_valid);
`else
        pop     = (count != '0) && ready_i;
        fifo_rd = pop;
`endif
        state_n       = state;
        wptr_n        = wptr + PtrW'(rsp);
        rptr_n        = rptr + PtrW'(fifo_rd);
        count_n       = count + OccW'(rsp) - OccW'(fifo_rd);
        outstanding_n = outstanding + OutW'(grant) - OutW'(rsp);
        discard_n     = discard - OutW'(drop);
        remaining_n   = remaining - CntWidth'(grant);
        popleft_n     = (popleft != '0) ? popleft - CntWidth'(pop) : popleft;
        done_n        = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    if (beats_i != '0) begin
                        remaining_n = beats_i;
                        popleft_n   = beats_i;
                        state_n     = RUN;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (pop && (popleft == CntWidth'(1))) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            DRAIN: begin
                if (discard_n == '0) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Flush: every request still in flight (including this cycle's grant) becomes a response to drop.
        if (clr_i) begin
            wptr_n        = '0;
            rptr_n        = '0;
            count_n       = '0;
            remaining_n   = '0;
            popleft_n     = '0;
            discard_n     = discard_n + outstanding_n;
            outstanding_n = '0;
            done_n        = 1'b0;
            state_n       = (discard_n != '0) ? DRAIN : IDLE;
`ifdef HYPERBUS_TX_PREFETCH_OUTREG_EN
            out_valid_n   = 1'b0;
`endif
        end

`ifdef HYPERBUS_TX_PREFETCH_OUTREG_EN
        occ_n = count_n + OccW'(out_valid_n);
`else
        occ_n = count_n;
`endif
        req_n = (state_n == RUN) && (remaining_n != '0) &&
                (outstanding_n < OutW'(MaxOutstanding)) &&
                ((SumW'(occ_n) + SumW'(outstanding_n)) < SumW'(Depth));
    end

    always_ff @(posedge clk_i) begin
        if (rsp) begin
            mem[wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            remaining   <= '0;
            popleft     <= '0;
            req_o       <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
`ifdef HYPERBUS_TX_PREFETCH_OUTREG_EN
            out_valid   <= 1'b0;
            out_data    <= '0;
`endif
        end else begin
            state       <= state_n;
            wptr        <= wptr_n;
            rptr        <= rptr_n;
            count       <= count_n;
            outstanding <= outstanding_n;
            discard     <= discard_n;
            remaining   <= remaining_n;
            popleft     <= popleft_n;
            req_o       <= req_n;
            busy_o      <= (state_n != IDLE);
            done_o      <= done_n;
`ifdef HYPERBUS_TX_PREFETCH_OUTREG_EN
            out_valid   <= out_valid_n;
            if (fifo_rd && !clr_i) begin
                out_data <= mem[rptr];
            end
`endif
        end
    end

endmodule

// File: tb/tb_hyperbus_udma_tx_prefetch.sv
// Directed bench for hyperbus_udma_tx_prefetch (default build) with a latency-programmable uDMA responder.
module tb_hyperbus_udma_tx_prefetch;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          clk_i = 1'b0;
    logic          rstn_i, clr_i, start_i, gnt_i, ready_i;
    logic [CW-1:0] beats_i;
    logic          busy_o, done_o, req_o, ready_o, valid_o;
    logic          valid_i = 1'b0;
    logic [DW-1:0] data_i  = '0;
    logic [DW-1:0] data_o;

    hyperbus_udma_tx_prefetch #(
        .DataWidth(DW),
        .Depth(4),
        .MaxOutstanding(2),
        .CntWidth(CW)
    ) dut (
        .clk_i(clk_i),
        .rstn_i(rstn_i),
        .clr_i(clr_i),
        .start_i(start_i),
        .beats_i(beats_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .req_o(req_o),
        .gnt_i(gnt_i),
        .valid_i(valid_i),
        .data_i(data_i),
        .ready_o(ready_o),
        .data_o(data_o),
        .valid_o(valid_o),
        .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    int unsigned   lat = 1;
    int unsigned   cyc = 0, ndata = 32'h100;
    int unsigned   n_req = 0, n_grants = 0, n_pops = 0, n_done = 0, n_valid = 0, n_vo = 0, max_pend = 0;
    int unsigned   pend[$];
    logic [DW-1:0] pops[$];

    // Monitor at posedge (pre-update values), responder drives valid_i/data_i at negedge.
    always begin
        @(posedge clk_i);
        if (!rstn_i) begin
            pend.delete();
        end else begin
            if (req_o) n_req++;
            if (req_o && gnt_i) begin
                pend.push_back(cyc + lat);
                n_grants++;
                if (pend.size() > max_pend) max_pend = pend.size();
            end
            if (valid_o && ready_i) begin
                pops.push_back(data_o);
                n_pops++;
            end
            if (done_o) n_done++;
            if (valid_i) n_valid++;
            if (valid_o) n_vo++;
        end
        cyc++;
        @(negedge clk_i);
        if (!rstn_i) begin
            pend.delete();
            valid_i = 1'b0;
        end else if (pend.size() > 0 && pend[0] <= cyc) begin
            void'(pend.pop_front());
            valid_i = 1'b1;
            data_i  = ndata;
            ndata++;
        end else begin
            valid_i = 1'b0;
        end
    end

    int unsigned n_checks = 0, n_errors = 0;
    int unsigned g0, p0, d0, r0, v0, vo0, base;
    logic        mid_ok;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic snap();
        g0  = n_grants;
        p0  = pops.size();
        d0  = n_done;
        r0  = n_req;
        v0  = n_valid;
        vo0 = n_vo;
    endtask

    task automatic launch(input int unsigned beats);
        start_i = 1'b1;
        beats_i = CW'(beats);
        tick();
        start_i = 1'b0;
        beats_i = '0;
    endtask

    task automatic wait_done(input int unsigned max_cyc, input string tag);
        for (int unsigned i = 0; i < max_cyc && n_done == d0; i++) tick();
        chk(tag, 64'(n_done != d0), 64'(1));
    endtask

    task automatic check_pops(input int unsigned n, input int unsigned first, input string tag);
        chk({tag, "_npops"}, 64'(pops.size() - p0), 64'(n));
        for (int unsigned i = 0; i < n; i++) begin
            if (p0 + i < pops.size()) chk({tag, "_data"}, 64'(pops[p0 + i]), 64'(first + i));
        end
    endtask

    initial begin
        rstn_i = 1'b0; clr_i = 1'b0; start_i = 1'b0; beats_i = '0;
        gnt_i = 1'b0; ready_i = 1'b0;
        repeat (3) tick();
        chk("rst_req",   64'(req_o),   64'(0));
        chk("rst_valid", 64'(valid_o), 64'(0));
        chk("rst_done",  64'(done_o),  64'(0));
        chk("rst_busy",  64'(busy_o),  64'(0));
        chk("rst_data",  64'(data_o),  64'(0));
        chk("rst_ready", 64'(ready_o), 64'(1));
        rstn_i = 1'b1;
        tick();

        // 8 beats, grant always, response one cycle after grant, sink always ready
        snap(); base = ndata;
        gnt_i = 1'b1; ready_i = 1'b1; lat = 1;
        launch(8);
        wait_done(100, "A_done_wait");
        repeat (3) tick();
        chk("A_grants", 64'(n_grants - g0), 64'(8));
        chk("A_done",   64'(n_done - d0),   64'(1));
        chk("A_busy",   64'(busy_o),        64'(0));
        check_pops(8, base, "A");

        // Sink stalled: exactly Depth grants, then one pop frees exactly one more grant
        snap(); base = ndata;
        ready_i = 1'b0;
        launch(10);
        repeat (20) tick();
        chk("B_grants4", 64'(n_grants - g0), 64'(4));
        chk("B_req_low", 64'(req_o),         64'(0));
        chk("B_valid",   64'(valid_o),       64'(1));
        chk("B_head",    64'(data_o),        64'(base));
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        repeat (10) tick();
        chk("B_grants5", 64'(n_grants - g0),   64'(5));
        chk("B_pops1",   64'(pops.size() - p0), 64'(1));
        ready_i = 1'b1;
        wait_done(100, "B_done_wait");
        repeat (2) tick();
        chk("B_done", 64'(n_done - d0), 64'(1));
        check_pops(10, base, "B");

        // Slow responses: unanswered grants must saturate at MaxOutstanding
        snap(); base = ndata;
        lat = 5;
        launch(6);
        wait_done(200, "C_done_wait");
        repeat (2) tick();
        chk("C_maxpend", 64'(max_pend),    64'(2));
        chk("C_done",    64'(n_done - d0), 64'(1));
        check_pops(6, base, "C");

        // Flush with two requests in flight: drain both responses silently
        snap();
        launch(8);
        repeat (2) tick();
        chk("D_req_stall", 64'(req_o),         64'(0));
        chk("D_grants",    64'(n_grants - g0), 64'(2));
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("D_busy_drain", 64'(busy_o), 64'(1));
        chk("D_req_clr",    64'(req_o),  64'(0));
        mid_ok = 1'b0;
        for (int unsigned i = 0; i < 20 && busy_o; i++) begin
            tick();
            if (n_valid - v0 == 1 && busy_o) mid_ok = 1'b1;
        end
        chk("D_busy_mid", 64'(mid_ok),        64'(1));
        chk("D_busy_end", 64'(busy_o),        64'(0));
        chk("D_valids",   64'(n_valid - v0),  64'(2));
        chk("D_vo",       64'(n_vo - vo0),    64'(0));
        chk("D_done",     64'(n_done - d0),   64'(0));
        chk("D_pops",     64'(pops.size() - p0), 64'(0));

        // Zero-beat start: immediate done, no request
        snap();
        lat = 1;
        launch(0);
        chk("E_done_hi", 64'(done_o), 64'(1));
        chk("E_busy",    64'(busy_o), 64'(0));
        tick();
        chk("E_done_lo", 64'(done_o), 64'(0));
        repeat (3) tick();
        chk("E_req",     64'(n_req - r0),  64'(0));
        chk("E_ndone",   64'(n_done - d0), 64'(1));

        // Reset mid-transfer, then a fresh 3-beat transfer
        ready_i = 1'b0;
        launch(8);
        repeat (4) tick();
        chk("F_busy_pre", 64'(busy_o), 64'(1));
        rstn_i = 1'b0;
        #1;
        chk("F_req",   64'(req_o),   64'(0));
        chk("F_valid", 64'(valid_o), 64'(0));
        chk("F_busy",  64'(busy_o),  64'(0));
        chk("F_done",  64'(done_o),  64'(0));
        chk("F_data",  64'(data_o),  64'(0));
        chk("F_ready", 64'(ready_o), 64'(1));
        repeat (2) tick();
        rstn_i = 1'b1;
        tick();
        snap(); base = ndata;
        ready_i = 1'b1;
        launch(3);
        wait_done(100, "F_done_wait");
        repeat (2) tick();
        chk("F_ndone",  64'(n_done - d0),  64'(1));
        chk("F_valids", 64'(n_valid - v0), 64'(3));
        check_pops(3, base, "F");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
